or1200_pad_engine: RTL

Responder side of the encryption pad handshake (enc_start/enc_key/enc_seed in, enc_pad/enc_done out) driven by the load-store encryption FSM. On an enc_start pulse it latches key and seed, then runs an iterative 32-bit ARX round function over a 128-bit state for ROUNDS cycles. It returns a 128-bit keystream pad with a one-cycle enc_done pulse. Sits between the encryption FSM and nothing else; purely datapath plus FSM, no memory interface.

---
 rtl/or1200_pad_engine_if.sv | 11 +
 rtl/or1200_pad_engine.sv | 73 +++++++
 2 files changed

// File: rtl/or1200_pad_engine_if.sv
// or1200_pad_engine_if: encryption pad handshake between the load-store encryption FSM and the pad engine
interface or1200_pad_engine_if;
  logic         enc_start;
  logic [127:0] enc_key;
  logic [127:0] enc_seed;
  logic [127:0] enc_pad;
  logic         enc_done;
  logic         busy;
  modport master (output enc_start, enc_key, enc_seed, input enc_pad, enc_done, busy);
  modport slave  (input enc_start, enc_key, enc_seed, output enc_pad, enc_done, busy);
endinterface

// File: rtl/or1200_pad_engine.sv
// or1200_pad_engine: iterative 32-bit ARX round engine producing a 128-bit keystream pad
module or1200_pad_engine #(
  parameter int ROUNDS = 8
) (
  input logic                  clk,
  input logic                  rst,
  or1200_pad_engine_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [7:0] LAST = 8'(ROUNDS - 1);
  state_t       state_q, state_d;
  logic [127:0] s_q, s_d, k_q, k_d, pad_q, pad_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [31:0]  rk, t0, t1, t2, t3;
  // one ARX round on the current state, round key picked by cnt mod 4
  always_comb begin
    rk = k_q[{cnt_q[1:0], 5'd0} +: 32];
    t0 = (s_q[31:0] + s_q[63:32]) ^ rk;
    t1 = {s_q[56:32], s_q[63:57]} ^ t0;
    t2 = s_q[95:64] + t1;
    t3 = {s_q[114:96], s_q[127:115]} ^ t2;
  end
  // next-state and datapath updates; done defaults low so it pulses for one cycle
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    pad_d   = pad_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.enc_start) begin
        s_d     = bus.enc_seed ^ bus.enc_key;
        k_d     = bus.enc_key;
        cnt_d   = 8'd0;
        state_d = ROUND;
      end
      ROUND: begin
        s_d     = {t0, t3, t2, t1};
        cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 8'd1;
        state_d = (cnt_q == LAST) ? DONE : ROUND;
      end
      DONE: begin
        pad_d   = s_q ^ k_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously so a reset abandons any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      pad_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
      done_q  <= done_d;
    end
  end
  assign bus.enc_pad  = pad_q;
  assign bus.enc_done = done_q;
  assign bus.busy     = (state_q != IDLE);
endmodule
